// File: rtl/mmio_timer_pkg.sv
// Shared register map and CTRL field positions for the memory-mapped timer
// and interrupt controller.
package mmio_timer_pkg;

  // Per-channel word offsets (channel i lives at word 4*i + offset).
  localparam logic [5:0] OFF_COUNT   = 6'h00;
  localparam logic [5:0] OFF_COMPARE = 6'h01;
  localparam logic [5:0] OFF_CTRL    = 6'h02;

  // Global words.
  localparam logic [5:0] OFF_PENDING = 6'h30;
  localparam logic [5:0] OFF_MASK    = 6'h31;
  localparam logic [5:0] OFF_STATUS  = 6'h32;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_PER     = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_PRE_LSB = 8;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: COUNT/COMPARE/CTRL registers, prescaler and match logic.
// match_pulse is high for the single cycle in which the channel's pending bit must set.
module timer_channel
  import mmio_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             wr_count,
  input  logic             wr_compare,
  input  logic             wr_ctrl,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] compare,
  output logic [31:0]      ctrl_word,
  output logic             ie,
  output logic             match_pulse
);

  logic             en;
  logic             periodic;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             hit;
  logic             unused_wdata;

  assign tick        = en && (pre_cnt == prescale);
  assign hit         = (count == compare);
  // A COUNT write on a tick cycle suppresses match evaluation entirely.
  assign match_pulse = tick && hit && !wr_count;
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (!en || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count <= '0;
    end else if (wr_count) begin
      count <= wdata[CNT_W-1:0];
    end else if (tick) begin
      if (!hit) begin
        count <= count + CNT_W'(1);
      end else if (periodic) begin
        count <= '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      compare <= '0;
    end else if (wr_compare) begin
      compare <= wdata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
    end else if (wr_ctrl) begin
      en       <= wdata[CTRL_EN];
      periodic <= wdata[CTRL_PER];
      ie       <= wdata[CTRL_IE];
      prescale <= wdata[CTRL_PRE_LSB +: PRE_W];
    end else if (match_pulse && !periodic) begin
      en <= 1'b0;
    end
  end

  always_comb begin
    ctrl_word                            = '0;
    ctrl_word[CTRL_EN]                   = en;
    ctrl_word[CTRL_PER]                  = periodic;
    ctrl_word[CTRL_IE]                   = ie;
    ctrl_word[CTRL_PRE_LSB +: PRE_W]     = prescale;
  end

endmodule

// File: rtl/mmio_timer_intc.sv
// Memory-mapped N-channel timer plus edge-triggered external interrupt latch,
// driving the CPU's 6-bit interrupt vector.
module mmio_timer_intc
  import mmio_timer_pkg::*;
#(
  parameter int          N_TIMER = 2,
  parameter int          CNT_W   = 32,
  parameter int          PRE_W   = 8,
  parameter int          N_EXT   = 5,
  parameter logic [31:0] BASE    = 32'h1001_8000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             bus_ena,
  input  logic             bus_w,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic [N_EXT-1:0] ext_irq,
  output logic [5:0]       int_o,
  output logic [31:0]      count0,
  output logic [31:0]      compare0
);

  localparam int NP = N_TIMER + N_EXT;

  // Bus protocol: single-cycle strobe, no backpressure. A write commits on the
  // clk_in edge where bus_ena & bus_w; read data is combinational in the same
  // cycle as bus_ena & ~bus_w and shows pre-edge values; otherwise bus_rdata = 0.
  logic       in_win;
  logic       wr;
  logic       rd;
  logic [5:0] word;
  logic       unused_addr;

  assign in_win      = (bus_addr[31:8] == BASE[31:8]);
  assign word        = bus_addr[7:2];
  assign wr          = bus_ena & bus_w & in_win;
  assign rd          = bus_ena & ~bus_w & in_win;
  assign unused_addr = ^bus_addr[1:0];

  logic [CNT_W-1:0]   cnt      [N_TIMER];
  logic [CNT_W-1:0]   cmp      [N_TIMER];
  logic [31:0]        ctrl_w   [N_TIMER];
  logic [N_TIMER-1:0] ie_vec;
  logic [N_TIMER-1:0] match_vec;
  logic [N_TIMER-1:0] cmp_wr;

  for (genvar i = 0; i < N_TIMER; i++) begin : g_ch
    logic wr_count;
    logic wr_compare;
    logic wr_ctrl;

    assign wr_count   = wr && (word == 6'(4 * i) + OFF_COUNT);
    assign wr_compare = wr && (word == 6'(4 * i) + OFF_COMPARE);
    assign wr_ctrl    = wr && (word == 6'(4 * i) + OFF_CTRL);
    assign cmp_wr[i]  = wr_compare;

    timer_channel #(
      .CNT_W(CNT_W),
      .PRE_W(PRE_W)
    ) u_ch (
      .clk_in     (clk_in),
      .reset      (reset),
      .wr_count   (wr_count),
      .wr_compare (wr_compare),
      .wr_ctrl    (wr_ctrl),
      .wdata      (bus_wdata),
      .count      (cnt[i]),
      .compare    (cmp[i]),
      .ctrl_word  (ctrl_w[i]),
      .ie         (ie_vec[i]),
      .match_pulse(match_vec[i])
    );
  end

  logic [NP-1:0]    pending;
  logic [NP-1:0]    mask;
  logic [NP-1:0]    set_vec;
  logic [NP-1:0]    clr_vec;
  logic [N_EXT-1:0] ext_prev;
  logic [5:0]       int_next;

  assign set_vec = {ext_irq & ~ext_prev, match_vec};

  // W1C from the PENDING word, plus the CP0-style clear on any COMPARE write.
  always_comb begin
    clr_vec = '0;
    if (wr && word == OFF_PENDING) clr_vec = bus_wdata[NP-1:0];
    clr_vec[N_TIMER-1:0] = clr_vec[N_TIMER-1:0] | cmp_wr;
  end

  always_comb begin
    int_next    = '0;
    int_next[0] = |(pending[N_TIMER-1:0] & mask[N_TIMER-1:0] & ie_vec);
    for (int j = 0; j < N_EXT; j++) begin
      int_next[j+1] = pending[N_TIMER+j] & mask[N_TIMER+j];
    end
  end

  // Set is ORed after the clear so a same-cycle event wins over W1C.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pending  <= '0;
      mask     <= '0;
      ext_prev <= '0;
      int_o    <= '0;
    end else begin
      pending  <= (pending & ~clr_vec) | set_vec;
      ext_prev <= ext_irq;
      int_o    <= int_next;
      if (wr && word == OFF_MASK) mask <= bus_wdata[NP-1:0];
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (rd) begin
      for (int k = 0; k < N_TIMER; k++) begin
        if (word == 6'(4 * k) + OFF_COUNT)   bus_rdata = 32'(cnt[k]);
        if (word == 6'(4 * k) + OFF_COMPARE) bus_rdata = 32'(cmp[k]);
        if (word == 6'(4 * k) + OFF_CTRL)    bus_rdata = ctrl_w[k];
      end
      if (word == OFF_PENDING) bus_rdata = 32'(pending);
      if (word == OFF_MASK)    bus_rdata = 32'(mask);
      if (word == OFF_STATUS)  bus_rdata = 32'(pending & mask);
    end
  end

  assign count0   = 32'(cnt[0]);
  assign compare0 = 32'(cmp[0]);

endmodule

// File: doc/mmio_timer_intc.md
# mmio_timer_intc

Memory-mapped, parametrised timer and interrupt controller on the CPU data bus, beside DMEM. It generalises the single CP0 count/compare timer into N independent channels. Each channel has a prescaler, one-shot or periodic mode and a per-channel interrupt enable. The block also latches edge-triggered external interrupts into a write-1-to-clear pending register and drives the CPU's 6-bit `int_i` vector.

## Interface
- `N_TIMER`, 2, number of timer channels (1..4)
- `CNT_W`, 32, counter/compare width (8..32); reads zero-extended
- `PRE_W`, 8, prescaler width (1..16)
- `N_EXT`, 5, external interrupt inputs (0..5)
- `BASE`, 32'h1001_8000, byte base address; window is 256 bytes
- `clk_in` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `bus_ena` in 1: bus access strobe
- `bus_w` in 1: 1 = write, 0 = read
- `bus_addr` in 32: byte address; decoded when `bus_addr[31:8] == BASE[31:8]`; `[7:2]` selects the word
- `bus_wdata` in 32: write data
- `bus_rdata` out 32: read data
- `ext_irq` in N_EXT: level inputs, already synchronous to `clk_in`
- `int_o` out 6: to CPU `int_i`
  - `[0]` = any enabled timer interrupt
  - `[N_EXT:1]` = external interrupts
  - unused bits are 0
- `count0`, `compare0` out 32: channel 0 COUNT/COMPARE for debug display

## Operation
- Channel i register words (word index = `addr[7:2]`):
  - 4i+0 COUNT (RW)
  - 4i+1 COMPARE (RW)
  - 4i+2 CTRL (RW): bit0 EN, bit1 PERIODIC, bit2 IE, bits[8+PRE_W-1:8] PRESCALE
  - 4i+3 reads 0
- Global words:
  - 0x30 PENDING: bits[N_TIMER-1:0] timers, bits[N_TIMER+N_EXT-1:N_TIMER] external; write-1-to-clear
  - 0x31 MASK (RW), same bit layout
  - 0x32 STATUS = PENDING & MASK (read-only)
- Unmapped words read 0 and ignore writes. Out-of-window accesses are ignored, and `bus_rdata` = 0.
- Prescaler: when EN = 1, `pre_cnt` increments each cycle. A tick fires when `pre_cnt == PRESCALE`, and `pre_cnt` then returns to 0. PRESCALE = 0 gives a tick every cycle. EN = 0 holds `pre_cnt` at 0.
- On a tick with COUNT == COMPARE:
  - set the channel's PENDING bit
  - PERIODIC = 1: COUNT <= 0
  - PERIODIC = 0: EN clears and COUNT holds
- On a tick without a match: COUNT <= COUNT+1, wrapping modulo 2^CNT_W.
- A COUNT write in the same cycle as a tick: the write wins, with no match evaluation and no increment.
- A COMPARE write clears that channel's PENDING bit (CP0 semantics).
- External interrupt: PENDING bit sets on a rising edge of `ext_irq[j]` (previous sample 0, current 1). Holding the input high does not re-set the bit after a clear.
- A set and a W1C on the same bit in the same cycle: the set wins.
- Interrupt outputs, registered:
  - `int_o[0] <= |(PENDING_t & MASK_t & IE)`
  - `int_o[j+1] <= PENDING_e[j] & MASK_e[j]`
- Reset values: COUNT, COMPARE, CTRL, PENDING, MASK, prescalers, edge samples and `int_o` all 0.
- Reset overrides any same-cycle write.

## Timing
- Writes commit on the `clk_in` edge where `bus_ena & bus_w` is true.
- Reads are combinational: `bus_rdata` is valid in the same cycle as `bus_ena & ~bus_w`, and reflects pre-edge register values.
- `bus_rdata` = 0 when `bus_ena` = 0.
- Match latency: PENDING sets on edge k, where the tick and COUNT == COMPARE hold before edge k. `int_o` asserts at edge k+1.
- External latency: `ext_irq` rises before edge k → PENDING set at edge k → `int_o` at edge k+1.
- W1C at edge k → `int_o` deasserts at edge k+1.
- Period with PRESCALE = p, COMPARE = c, PERIODIC: (p+1)·(c+1) cycles between pending sets.
- `count0`/`compare0` are direct register outputs, zero-extended.

## Structure
- Package `mmio_timer_pkg` holds:
  - word offsets: `OFF_COUNT`, `OFF_COMPARE`, `OFF_CTRL`, `OFF_PENDING`, `OFF_MASK`, `OFF_STATUS`
  - CTRL bit indices: `CTRL_EN`, `CTRL_PER`, `CTRL_IE`, `CTRL_PRE_LSB`
- Sub-module `timer_channel` (parameters `CNT_W`, `PRE_W`) contains:
  - COUNT, COMPARE, CTRL and prescaler
  - match logic
  - write ports, and a `match_pulse` output
- `timer_channel` is instantiated N_TIMER times via generate.
- The top level owns address decode, the PENDING/MASK registers, edge detection, the read mux and `int_o`.

## Test plan
- Reset with garbage on all inputs → all reads 0, `int_o` = 0, `count0` = 0.
- Ch0: COMPARE = 3, CTRL = EN|PERIODIC|IE, PRESCALE = 0, MASK = 1 → pending every 4 cycles; `int_o[0]` rises one cycle after PENDING[0]; W1C 0x1 drops it next cycle.
- Ch1: PRESCALE = 2, COMPARE = 1, one-shot → COUNT 0→1 over 3-cycle ticks; match at cycle 6, EN reads 0, COUNT holds 1.
- COUNT write of 5 in the same cycle as a tick → COUNT reads 5. Writing COMPARE clears PENDING[0] with no W1C.
- `ext_irq[0]` held high 10 cycles with MASK bit N_TIMER set → PENDING set once. After W1C it stays clear; `int_o[1]` follows one cycle after PENDING.
- Simultaneous match and W1C on the same bit → bit remains 1. Synchronous reset asserted mid-period → COUNT = 0 on the next edge, and `int_o` = 0.
